// File: rtl/dbg_guv_cmd_tx.sv
// Command transmitter at the head of the dbg_guv chain: serializes each register
// write into a header word plus MSB-first value words, then holds a fixed idle gap.
module dbg_guv_cmd_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int REG_WIDTH  = 4,
  parameter int VAL_WIDTH  = 32,
  parameter int GAP        = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_reg,
  input  logic [VAL_WIDTH-1:0]  req_val,
  input  logic                  req_TVALID,
  output logic                  req_TREADY,
  output logic [DATA_WIDTH-1:0] cmd_out_TDATA,
  output logic                  cmd_out_TVALID,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cmd_count
);
  // state  | meaning
  // S_IDLE | waiting for a request, req_TREADY high
  // S_HDR  | header word {addr, reg} on cmd_out
  // S_VAL  | value words on cmd_out, MSB word first
  // S_GAP  | forced idle cycles after the last value word
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_VAL, S_GAP} state_t;

  localparam int NUM_WORDS = (VAL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int TOT_WIDTH = NUM_WORDS * DATA_WIDTH;
  localparam int MAX_LOAD  = (NUM_WORDS > GAP) ? NUM_WORDS : GAP;
  localparam int TMR_WIDTH = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
  localparam int GAP_LOAD  = (GAP > 0) ? GAP - 1 : 0;

  state_t                 r_state;
  logic [TOT_WIDTH-1:0]   r_val;
  logic [TMR_WIDTH-1:0]   r_tmr;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   r_tvalid;
  logic                   r_busy;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [DATA_WIDTH-1:0]  w_hdr;
  logic [TOT_WIDTH-1:0]   w_val_ext;

  assign w_hdr          = DATA_WIDTH'({req_addr, req_reg});
  assign w_val_ext      = TOT_WIDTH'(req_val);
  assign req_TREADY     = (r_state == S_IDLE) && rst;
  assign cmd_out_TDATA  = r_tdata;
  assign cmd_out_TVALID = r_tvalid;
  assign busy           = r_busy;
  assign cmd_count      = r_count;

  // Outputs are loaded on the transition into the state that presents them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_val    <= '0;
      r_tmr    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_TVALID) begin
            r_state  <= S_HDR;
            r_val    <= w_val_ext;
            r_tdata  <= w_hdr;
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_HDR: begin
          r_state <= S_VAL;
          r_tdata <= r_val[TOT_WIDTH-1 -: DATA_WIDTH];
          r_val   <= r_val << DATA_WIDTH;
          r_tmr   <= TMR_WIDTH'(NUM_WORDS - 1);
        end
        S_VAL: begin
          if (r_tmr == '0) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_count  <= r_count + 1'b1;
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_tmr   <= TMR_WIDTH'(GAP_LOAD);
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tmr   <= r_tmr - 1'b1;
            r_tdata <= r_val[TOT_WIDTH-1 -: DATA_WIDTH];
            r_val   <= r_val << DATA_WIDTH;
          end
        end
        S_GAP: begin
          if (r_tmr == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tdata  <= '0;
          r_tvalid <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_guv_cmd_tx.sv
// Bench for dbg_guv_cmd_tx: four instances (default, 20-bit value, no gap, 2-bit count)
// with a per-instance expected-word queue checked whenever cmd_out is valid.
module tb_dbg_guv_cmd_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  a0, a1, a2, a3;
  logic [3:0]  r0, r1, r2, r3;
  logic [31:0] v0, v2, v3;
  logic [19:0] v1;
  logic        tv0, tv1, tv2, tv3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [15:0] d0, d1, d2, d3;
  logic        vld0, vld1, vld2, vld3;
  logic        busy0, busy1, busy2, busy3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  dbg_guv_cmd_tx u0 (.clk(clk), .rst(rst), .req_addr(a0), .req_reg(r0), .req_val(v0),
    .req_TVALID(tv0), .req_TREADY(rdy0), .cmd_out_TDATA(d0), .cmd_out_TVALID(vld0),
    .busy(busy0), .cmd_count(cnt0));
  dbg_guv_cmd_tx #(.VAL_WIDTH(20)) u1 (.clk(clk), .rst(rst), .req_addr(a1), .req_reg(r1),
    .req_val(v1), .req_TVALID(tv1), .req_TREADY(rdy1), .cmd_out_TDATA(d1),
    .cmd_out_TVALID(vld1), .busy(busy1), .cmd_count(cnt1));
  dbg_guv_cmd_tx #(.GAP(0)) u2 (.clk(clk), .rst(rst), .req_addr(a2), .req_reg(r2),
    .req_val(v2), .req_TVALID(tv2), .req_TREADY(rdy2), .cmd_out_TDATA(d2),
    .cmd_out_TVALID(vld2), .busy(busy2), .cmd_count(cnt2));
  dbg_guv_cmd_tx #(.CNT_WIDTH(2)) u3 (.clk(clk), .rst(rst), .req_addr(a3), .req_reg(r3),
    .req_val(v3), .req_TVALID(tv3), .req_TREADY(rdy3), .cmd_out_TDATA(d3),
    .cmd_out_TVALID(vld3), .busy(busy3), .cmd_count(cnt3));

  // {is_header, word}
  logic [16:0] q[4][$];
  int          hdr_cyc[4];
  logic        prev_vld[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void pushw(input int k, input logic h, input logic [15:0] w);
    q[k].push_back({h, w});
  endfunction

  function automatic logic get_rdy(input int k);
    case (k)
      0: return rdy0;
      1: return rdy1;
      2: return rdy2;
      default: return rdy3;
    endcase
  endfunction

  task automatic mon(input int k, input logic vld, input logic [15:0] d);
    logic [16:0] e;
    if (vld === 1'b1) begin
      chk($sformatf("u%0d_unexpected_word", k), 32'(q[k].size() > 0), 32'd1);
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        chk($sformatf("u%0d_word", k), 32'(d), 32'(e[15:0]));
        if (e[16]) hdr_cyc[k] = cyc;
        else chk($sformatf("u%0d_gapless", k), 32'(prev_vld[k]), 32'd1);
      end
    end else begin
      chk($sformatf("u%0d_idle_data", k), 32'(d), 32'd0);
    end
    prev_vld[k] = vld;
  endtask

  always @(negedge clk) begin
    mon(0, vld0, d0);
    mon(1, vld1, d1);
    mon(2, vld2, d2);
    mon(3, vld3, d3);
  end

  // Called between edges with inputs already driven; returns the handshake cycle.
  task automatic hs(input int k, output int n);
    int t = 0;
    while (!get_rdy(k) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d_hs_timeout", k), 32'(get_rdy(k)), 32'd1);
    n = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    @(negedge clk);
    while (!get_rdy(k) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d_idle_timeout", k), 32'(get_rdy(k)), 32'd1);
  endtask

  task automatic run0(input logic [9:0] a, input logic [3:0] r, input logic [31:0] v,
                      input int expcnt);
    int n;
    pushw(0, 1'b1, {2'b00, a, r});
    pushw(0, 1'b0, v[31:16]);
    pushw(0, 1'b0, v[15:0]);
    a0 = a; r0 = r; v0 = v; tv0 = 1'b1;
    hs(0, n);
    tv0 = 1'b0; a0 = 10'($urandom); r0 = 4'($urandom); v0 = $urandom;
    @(negedge clk);
    chk("t1_hdr_vld", 32'(vld0), 32'd1);
    chk("t1_hdr_data", 32'(d0), 32'({2'b00, a, r}));
    chk("t1_busy", 32'(busy0), 32'd1);
    chk("t1_rdy_busy", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("t1_w0_vld", 32'(vld0), 32'd1);
    chk("t1_w0_data", 32'(d0), 32'(v[31:16]));
    @(negedge clk);
    chk("t1_w1_data", 32'(d0), 32'(v[15:0]));
    chk("t1_cnt_before", 32'(cnt0), 32'(expcnt - 1));
    @(negedge clk);
    chk("t1_gap_vld", 32'(vld0), 32'd0);
    chk("t1_gap_busy", 32'(busy0), 32'd1);
    chk("t1_gap_rdy", 32'(rdy0), 32'd0);
    chk("t1_cnt_after", 32'(cnt0), 32'(expcnt));
    @(negedge clk);
    chk("t1_rdy_back", 32'(rdy0), 32'd1);
    chk("t1_busy_back", 32'(busy0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, h1, t;
    logic [31:0] rv;
    logic [9:0]  ra;
    logic [3:0]  rr;
    for (int k = 0; k < 4; k++) begin
      hdr_cyc[k] = 0;
      prev_vld[k] = 1'b0;
    end
    {a0, a1, a2, a3} = '0;
    {r0, r1, r2, r3} = '0;
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    {tv0, tv1, tv2, tv3} = '0;
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tdata", 32'(d0), 32'd0);
    chk("rst_tvalid", 32'(vld0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_tready", 32'(rdy0), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rel_tready", 32'(rdy0), 32'd1);

    // basic command with exact timing
    run0(10'd1, 4'd3, 32'hDEADBEEF, 1);

    // back-to-back with req_TVALID held
    pushw(0, 1'b1, {2'b00, 10'd4, 4'd1}); pushw(0, 1'b0, 16'h0000); pushw(0, 1'b0, 16'h0001);
    pushw(0, 1'b1, {2'b00, 10'd5, 4'd2}); pushw(0, 1'b0, 16'h0000); pushw(0, 1'b0, 16'h0002);
    a0 = 10'd4; r0 = 4'd1; v0 = 32'h1; tv0 = 1'b1;
    hs(0, n1);
    a0 = 10'd5; r0 = 4'd2; v0 = 32'h2;
    t = 0;
    do begin
      @(negedge clk);
      if (!rdy0) chk("t2_busy_held", 32'(busy0), 32'd1);
      t++;
    end while (!rdy0 && t < 20);
    n2 = cyc;
    chk("t2_second_accept", 32'(n2), 32'(n1 + 5));
    h1 = hdr_cyc[0];
    chk("t2_first_hdr_cycle", 32'(h1), 32'(n1 + 1));
    @(posedge clk);
    #1 tv0 = 1'b0;
    @(negedge clk);
    #1;
    chk("t2_hdr_spacing", 32'(hdr_cyc[0] - h1), 32'd5);
    wait_idle(0);
    chk("t2_count", 32'(cnt0), 32'd3);

    // 20-bit value, full-width header fields
    pushw(1, 1'b1, 16'h3FFF); pushw(1, 1'b0, 16'h000A); pushw(1, 1'b0, 16'hBCDE);
    a1 = 10'h3FF; r1 = 4'hF; v1 = 20'hABCDE; tv1 = 1'b1;
    hs(1, n);
    tv1 = 1'b0; v1 = 20'h12345;
    wait_idle(1);
    chk("t3_count", 32'(cnt1), 32'd1);

    // GAP=0 back-to-back
    pushw(2, 1'b1, {2'b00, 10'h155, 4'hA}); pushw(2, 1'b0, 16'h1234); pushw(2, 1'b0, 16'h5678);
    pushw(2, 1'b1, {2'b00, 10'h2AA, 4'h5}); pushw(2, 1'b0, 16'h9ABC); pushw(2, 1'b0, 16'hDEF0);
    a2 = 10'h155; r2 = 4'hA; v2 = 32'h12345678; tv2 = 1'b1;
    hs(2, n1);
    a2 = 10'h2AA; r2 = 4'h5; v2 = 32'h9ABCDEF0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy2 && t < 20);
    n2 = cyc;
    chk("t4_second_accept", 32'(n2), 32'(n1 + 4));
    chk("t4_idle_on_accept", 32'(vld2), 32'd0);
    h1 = hdr_cyc[2];
    @(posedge clk);
    #1 tv2 = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_hdr_spacing", 32'(hdr_cyc[2] - h1), 32'd4);
    wait_idle(2);
    chk("t4_count", 32'(cnt2), 32'd2);

    // reset during the first value word
    pushw(0, 1'b1, 16'h0013); pushw(0, 1'b0, 16'hDEAD); pushw(0, 1'b0, 16'hBEEF);
    a0 = 10'd1; r0 = 4'd3; v0 = 32'hDEADBEEF; tv0 = 1'b1;
    hs(0, n);
    tv0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_w0_vld", 32'(vld0), 32'd1);
    chk("t5_w0_data", 32'(d0), 32'hDEAD);
    #1 rst = 1'b0;
    #1;
    chk("t5_async_vld", 32'(vld0), 32'd0);
    chk("t5_async_data", 32'(d0), 32'd0);
    chk("t5_async_busy", 32'(busy0), 32'd0);
    chk("t5_async_rdy", 32'(rdy0), 32'd0);
    q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cnt_cleared", 32'(cnt0), 32'd0);
    chk("t5_idle_rdy", 32'(rdy0), 32'd1);
    run0(10'h2A, 4'h6, 32'hCAFE0123, 1);

    // 2-bit count wrap, inputs scrambled while busy
    for (int i = 0; i < 5; i++) begin
      ra = 10'(i * 37 + 5);
      rr = 4'(i + 1);
      rv = $urandom;
      pushw(3, 1'b1, {2'b00, ra, rr});
      pushw(3, 1'b0, rv[31:16]);
      pushw(3, 1'b0, rv[15:0]);
      a3 = ra; r3 = rr; v3 = rv; tv3 = 1'b1;
      hs(3, n);
      tv3 = 1'b0; a3 = 10'($urandom); r3 = 4'($urandom); v3 = $urandom;
      wait_idle(3);
      chk($sformatf("t6_count_%0d", i), 32'(cnt3), 32'((i + 1) % 4));
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("u%0d_drain", k), 32'(q[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
